pam_slicer_multilane: RTL and testbench

- Multi-lane, parametrised PAM-L decision slicer for the Rx DFE feedback path. It sits between the per-lane ISI estimator and the DFE feedback / symbol sink.
- Maps each lane's signed estimate to the nearest ideal PAM level and its symbol index.
- Uses a 2-stage pipeline with valid/ready backpressure.
- Keeps a saturating overrange counter for link diagnostics.

---
 rtl/pam_slicer_multilane.sv | 202 ++++++++++++++++++++
 tb/tb_pam_slicer_multilane.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_slicer_multilane.sv
// Multi-lane PAM-L decision slicer: nearest-level decision, 2-stage valid/ready pipeline,
// saturating overrange counter. Define PAM_SLICER_GRAY_EN to emit Gray-coded symbols.
module pam_slicer_multilane #(
   parameter int LANES             = 4,
   parameter int SIGNAL_RESOLUTION = 8,
   parameter int PAM_BITS          = 2,
   parameter int SYMBOL_SEPERATION = 56,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [LANES*SIGNAL_RESOLUTION-1:0]  est_data_i,
   input  logic                                est_valid_i,
   output logic                                est_ready_o,
   output logic [LANES*SIGNAL_RESOLUTION-1:0]  dec_value_o,
   output logic [LANES*PAM_BITS-1:0]           dec_symbol_o,
   output logic                                dec_valid_o,
   input  logic                                dec_ready_i,
   input  logic                                clear_cnt_i,
   output logic [CNT_WIDTH-1:0]                overrange_cnt_o
);
   localparam int SR      = SIGNAL_RESOLUTION;
   localparam int SEP     = SYMBOL_SEPERATION;
   localparam int L       = 1 << PAM_BITS;
   localparam int CW      = SR + PAM_BITS + 1;
   localparam int OVR_LIM = (L * SEP) / 2;

   localparam logic signed [CW-1:0] OVR_HI = CW'(OVR_LIM);
   localparam logic signed [CW-1:0] OVR_LO = CW'(-OVR_LIM);

   if ((PAM_BITS < 1) || (PAM_BITS > 3) || (((L - 1) * SEP) / 2 > (1 << (SR - 1)) - 1) ||
       ((SEP % 2) != 0)) begin : g_param_check
      $error("pam_slicer_multilane: outer level exceeds signal range, SEP is odd or PAM_BITS unsupported");
   end

   function automatic logic signed [CW-1:0] thr_f(input int j);
      return CW'((j - L / 2) * SEP);
   endfunction

   // Widened compare so thresholds beyond the estimate range never wrap
   function automatic logic signed [CW-1:0] ext_f(input logic [SR-1:0] raw);
      return {{(PAM_BITS + 1){raw[SR-1]}}, raw};
   endfunction

   function automatic logic [PAM_BITS-1:0] slice_f(input logic [SR-1:0] raw);
      logic signed [CW-1:0] ext;
      logic [PAM_BITS-1:0]  k;
      ext = ext_f(raw);
      k   = {PAM_BITS{1'b0}};
      for (int j = 1; j < L; j++) begin
         if (ext >= thr_f(j)) begin
            k = k + PAM_BITS'(1'b1);
         end else begin
            k = k;
         end
      end
      return k;
   endfunction

   function automatic logic ovr_f(input logic [SR-1:0] raw);
      logic signed [CW-1:0] ext;
      ext = ext_f(raw);
      return (ext > OVR_HI) || (ext < OVR_LO);
   endfunction

   function automatic logic [SR-1:0] level_f(input logic [PAM_BITS-1:0] k);
      int kk;
      kk = int'(k);
      return SR'((2 * kk - (L - 1)) * (SEP / 2));
   endfunction

   function automatic logic [PAM_BITS-1:0] encode_f(input logic [PAM_BITS-1:0] k);
`ifdef PAM_SLICER_GRAY_EN
      return k ^ (k >> 1'b1);
`else
      return k;
`endif
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add_f(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic [LANES-1:0]     flags);
      logic [CNT_WIDTH-1:0] acc;
      acc = cnt;
      for (int i = 0; i < LANES; i++) begin
         if (flags[i] && (acc != {CNT_WIDTH{1'b1}})) begin
            acc = acc + CNT_WIDTH'(1'b1);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   logic [LANES*PAM_BITS-1:0] k_s;
   logic [LANES-1:0]          ovr_s;
   logic [LANES*SR-1:0]       lvl_s;
   logic [LANES*PAM_BITS-1:0] sym_s;
   logic                      s1_adv_s;
   logic                      s2_adv_s;
   logic                      accept_s;

   logic                      s1_valid_q, s1_valid_d;
   logic [LANES*PAM_BITS-1:0] s1_k_q, s1_k_d;
   logic                      dec_valid_q, dec_valid_d;
   logic [LANES*SR-1:0]       dec_value_q, dec_value_d;
   logic [LANES*PAM_BITS-1:0] dec_symbol_q, dec_symbol_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

   // Per-lane decision index and overrange flag straight from the incoming beat
   always_comb begin
      k_s   = {(LANES*PAM_BITS){1'b0}};
      ovr_s = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         k_s[i*PAM_BITS +: PAM_BITS] = slice_f(est_data_i[i*SR +: SR]);
         ovr_s[i]                    = ovr_f(est_data_i[i*SR +: SR]);
      end
   end

   // Ideal level and output code for the indices held in S1
   always_comb begin
      lvl_s = {(LANES*SR){1'b0}};
      sym_s = {(LANES*PAM_BITS){1'b0}};
      for (int i = 0; i < LANES; i++) begin
         lvl_s[i*SR +: SR]             = level_f(s1_k_q[i*PAM_BITS +: PAM_BITS]);
         sym_s[i*PAM_BITS +: PAM_BITS] = encode_f(s1_k_q[i*PAM_BITS +: PAM_BITS]);
      end
   end

   assign s2_adv_s    = !dec_valid_q || dec_ready_i;
   assign s1_adv_s    = !s1_valid_q || s2_adv_s;
   assign est_ready_o = rstn && s1_adv_s;
   assign accept_s    = est_valid_i && est_ready_o;

   // Next-state for both pipeline stages and the overrange counter
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_k_d       = s1_k_q;
      dec_valid_d  = dec_valid_q;
      dec_value_d  = dec_value_q;
      dec_symbol_d = dec_symbol_q;
      cnt_d        = cnt_q;

      if (s1_adv_s) begin
         s1_valid_d = est_valid_i;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (accept_s) begin
         s1_k_d = k_s;
      end else begin
         s1_k_d = s1_k_q;
      end

      if (s2_adv_s) begin
         dec_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            dec_value_d  = lvl_s;
            dec_symbol_d = sym_s;
         end else begin
            dec_value_d  = dec_value_q;
            dec_symbol_d = dec_symbol_q;
         end
      end else begin
         dec_valid_d = dec_valid_q;
      end

      // Clear beats a same-cycle increment
      if (clear_cnt_i) begin
         cnt_d = {CNT_WIDTH{1'b0}};
      end else if (accept_s) begin
         cnt_d = sat_add_f(cnt_q, ovr_s);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline and counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid_q   <= 1'b0;
         s1_k_q       <= {(LANES*PAM_BITS){1'b0}};
         dec_valid_q  <= 1'b0;
         dec_value_q  <= {(LANES*SR){1'b0}};
         dec_symbol_q <= {(LANES*PAM_BITS){1'b0}};
         cnt_q        <= {CNT_WIDTH{1'b0}};
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_k_q       <= s1_k_d;
         dec_valid_q  <= dec_valid_d;
         dec_value_q  <= dec_value_d;
         dec_symbol_q <= dec_symbol_d;
         cnt_q        <= cnt_d;
      end
   end

   assign dec_value_o     = dec_value_q;
   assign dec_symbol_o    = dec_symbol_q;
   assign dec_valid_o     = dec_valid_q;
   assign overrange_cnt_o = cnt_q;

endmodule

// File: tb/tb_pam_slicer_multilane.sv
// Scoreboard bench for pam_slicer_multilane: default 4-lane slicer, a 4-bit-counter
// instance for saturation/clear, and an 8-level single-lane instance for symbol coding.
`timescale 1ns/1ps
module tb_pam_slicer_multilane;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [31:0] est_data;
   logic        est_valid, est_ready;
   logic [31:0] dec_value;
   logic [7:0]  dec_symbol;
   logic        dec_valid, dec_ready, clear_cnt;
   logic [15:0] ovr_cnt;

   logic [31:0] c_est_data, c_dec_value;
   logic        c_est_valid, c_est_ready, c_dec_valid, c_dec_ready, c_clear;
   logic [7:0]  c_dec_symbol;
   logic [3:0]  c_cnt;

   logic [7:0]  g_est_data, g_dec_value;
   logic        g_est_valid, g_est_ready, g_dec_valid, g_dec_ready, g_clear;
   logic [2:0]  g_dec_symbol;
   logic [15:0] g_cnt;

   int checks = 0;
   int errors = 0;
   logic [39:0] q[$];
   logic [10:0] qg[$];

   pam_slicer_multilane dut (
      .clk(clk), .rstn(rstn), .est_data_i(est_data), .est_valid_i(est_valid),
      .est_ready_o(est_ready), .dec_value_o(dec_value), .dec_symbol_o(dec_symbol),
      .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .clear_cnt_i(clear_cnt),
      .overrange_cnt_o(ovr_cnt));

   pam_slicer_multilane #(.CNT_WIDTH(4)) dut_c (
      .clk(clk), .rstn(rstn), .est_data_i(c_est_data), .est_valid_i(c_est_valid),
      .est_ready_o(c_est_ready), .dec_value_o(c_dec_value), .dec_symbol_o(c_dec_symbol),
      .dec_valid_o(c_dec_valid), .dec_ready_i(c_dec_ready), .clear_cnt_i(c_clear),
      .overrange_cnt_o(c_cnt));

   pam_slicer_multilane #(.LANES(1), .PAM_BITS(3), .SYMBOL_SEPERATION(30)) dut_g (
      .clk(clk), .rstn(rstn), .est_data_i(g_est_data), .est_valid_i(g_est_valid),
      .est_ready_o(g_est_ready), .dec_value_o(g_dec_value), .dec_symbol_o(g_dec_symbol),
      .dec_valid_o(g_dec_valid), .dec_ready_i(g_dec_ready), .clear_cnt_i(g_clear),
      .overrange_cnt_o(g_cnt));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      logic [7:0] ba, bb, bc, bd;
      ba = a[7:0]; bb = b[7:0]; bc = c[7:0]; bd = d[7:0];
      return {ba, bb, bc, bd};
   endfunction

   function automatic logic [1:0] enc2(input int k);
      logic [1:0] b;
      b = k[1:0];
`ifdef PAM_SLICER_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   function automatic logic [2:0] enc3(input int k);
      logic [2:0] b;
      b = k[2:0];
`ifdef PAM_SLICER_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   function automatic logic [7:0] pks(input int a, input int b, input int c, input int d);
      return {enc2(a), enc2(b), enc2(c), enc2(d)};
   endfunction

   task automatic send(input logic [31:0] d, input logic [31:0] ev, input logic [7:0] es);
      int n;
      est_data  = d;
      est_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!est_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!est_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: est_ready stayed 0, expected 1");
      end else begin
         q.push_back({ev, es});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sendg(input logic [7:0] d, input logic [7:0] ev, input logic [2:0] es);
      g_est_data  = d;
      g_est_valid = 1'b1;
      @(negedge clk);
      chk("g_est_ready", g_est_ready, 1);
      if (g_est_ready) qg.push_back({ev, es});
      @(posedge clk);
      #1;
      g_est_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((q.size() != 0 || qg.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, q.size() + qg.size(), 0);
   endtask

   // Main-DUT monitor: pops on every transfer, checks hold stability under backpressure
   initial begin
      logic        hold_pend;
      logic [40:0] hold_val;
      logic [39:0] exp;
      hold_pend = 1'b0;
      hold_val  = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) chk("hold_stable", {dec_valid, dec_value, dec_symbol}, hold_val);
            if (dec_valid && dec_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %h/%h, expected no beat", dec_value, dec_symbol);
               end else begin
                  exp = q.pop_front();
                  chk("beat", {dec_value, dec_symbol}, exp);
               end
            end
            hold_pend = dec_valid && !dec_ready;
            hold_val  = {dec_valid, dec_value, dec_symbol};
         end
      end
   end

   // 8-level instance monitor
   initial begin
      logic [10:0] exp;
      forever begin
         @(negedge clk);
         if (rstn && g_dec_valid && g_dec_ready) begin
            if (qg.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL g_unexpected: got %h/%h, expected no beat", g_dec_value, g_dec_symbol);
            end else begin
               exp = qg.pop_front();
               chk("g_beat", {g_dec_value, g_dec_symbol}, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int in3 [8][4] = '{'{0, 0, 0, 0}, '{-1, -1, -1, -1}, '{60, -60, 10, -30},
                      '{112, -112, 57, -55}, '{20, 40, -20, -40}, '{80, 90, -80, -90},
                      '{1, -2, 3, -4}, '{-56, 56, -57, 57}};
   int ev3 [8][4] = '{'{28, 28, 28, 28}, '{-28, -28, -28, -28}, '{84, -84, 28, -28},
                      '{84, -84, 84, -28}, '{28, 28, -28, -28}, '{84, 84, -84, -84},
                      '{28, -28, 28, -28}, '{-28, 84, -84, 84}};
   int ek3 [8][4] = '{'{2, 2, 2, 2}, '{1, 1, 1, 1}, '{3, 0, 2, 1}, '{3, 0, 3, 1},
                      '{2, 2, 1, 1}, '{3, 3, 0, 0}, '{2, 1, 2, 1}, '{1, 3, 0, 3}};
   int csat [5] = '{4, 8, 12, 15, 15};

   initial begin
      logic saw_stall;
      rstn = 1'b0; est_data = '0; est_valid = 1'b0; dec_ready = 1'b1; clear_cnt = 1'b0;
      c_est_data = '0; c_est_valid = 1'b0; c_dec_ready = 1'b1; c_clear = 1'b0;
      g_est_data = '0; g_est_valid = 1'b0; g_dec_ready = 1'b1; g_clear = 1'b0;
      saw_stall = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_dec_value", dec_value, 0);
      chk("rst_dec_symbol", dec_symbol, 0);
      chk("rst_cnt", ovr_cnt, 0);
      chk("rst_est_ready", est_ready, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", est_ready, 1);
      @(posedge clk); #1;

      // Basic decision and 2-cycle latency
      send(pk(100, 30, -10, -70), pk(84, 28, -28, -84), pks(3, 2, 1, 0));
      est_valid = 1'b0;
      @(negedge clk);
      chk("lat_early", dec_valid, 0);
      @(negedge clk);
      chk("lat_on", dec_valid, 1);
      chk("t1_cnt", ovr_cnt, 0);
      @(posedge clk); #1;

      // Threshold boundaries and overrange extremes
      send(pk(56, 55, 0, -1), pk(84, 28, 28, -28), pks(3, 2, 2, 1));
      send(pk(-56, -57, 127, -128), pk(-28, -84, 84, -84), pks(1, 0, 3, 0));
      est_valid = 1'b0;
      @(negedge clk);
      chk("t2_cnt", ovr_cnt, 2);
      drain("t2_drain");
      @(posedge clk); #1;

      // Streaming with a 3-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(pk(in3[i][0], in3[i][1], in3[i][2], in3[i][3]),
                    pk(ev3[i][0], ev3[i][1], ev3[i][2], ev3[i][3]),
                    pks(ek3[i][0], ek3[i][1], ek3[i][2], ek3[i][3]));
            est_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 dec_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 dec_ready = 1'b1;
         end
         begin
            repeat (12) begin
               @(negedge clk);
               if (est_valid && !est_ready) saw_stall = 1'b1;
            end
         end
      join
      chk("t3_stall_seen", saw_stall, 1);
      drain("t3_drain");
      chk("t3_cnt", ovr_cnt, 2);
      @(posedge clk); #1;

      // Saturation and clear priority on the 4-bit counter instance
      c_est_data  = pk(120, 120, 120, 120);
      c_est_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk);
         @(negedge clk);
         chk("c_sat", c_cnt, csat[n]);
      end
      c_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("c_clear_wins", c_cnt, 0);
      c_clear = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("c_after_clear", c_cnt, 4);
      c_est_valid = 1'b0;
      @(posedge clk); #1;

      // Reset with two beats in flight
      dec_ready = 1'b0;
      send(pk(120, 0, 0, 0), pk(84, 28, 28, 28), pks(3, 2, 2, 2));
      send(pk(120, 0, 0, 0), pk(84, 28, 28, 28), pks(3, 2, 2, 2));
      est_valid = 1'b0;
      rstn = 1'b0;
      q.delete();
      @(negedge clk);
      chk("t5_cnt_pre", ovr_cnt, 4);
      chk("t5_ready_forced", est_ready, 0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("t5_rst_valid", dec_valid, 0);
         chk("t5_rst_cnt", ovr_cnt, 0);
         chk("t5_rst_ready", est_ready, 0);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      dec_ready = 1'b1;
      @(negedge clk);
      chk("t5_ready_after", est_ready, 1);
      repeat (5) begin
         @(negedge clk);
         chk("t5_no_stale", dec_valid, 0);
      end
      @(posedge clk); #1;

      // 8-level single-lane instance: levels -105..105 in steps of 30
      sendg(8'd50, 8'd45, enc3(5));
      sendg(8'h9C, 8'h97, enc3(0));
      sendg(8'd0, 8'd15, enc3(4));
      drain("g_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
